// File: rtl/latch_readout_pkg.sv
// Shared types and constants for the two-channel latched-counter readout framer.
// LATCH_READOUT_CHKSUM_EN adds the trailing XOR checksum state.
package latch_readout_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_DATA = 3'd2,
`ifdef LATCH_READOUT_CHKSUM_EN
        ST_CHK  = 3'd3,
`endif
        ST_ACK  = 3'd4
    } state_t;

    localparam int         DEF_WIDTH  = 64;
    localparam logic [7:0] DEF_HDR1   = 8'hA1;
    localparam logic [7:0] DEF_HDR2   = 8'hA2;
    localparam int         DEF_NBYTES = DEF_WIDTH / 8;

    // Byte counter is never narrower than 3 bits.
    function automatic int cnt_width(input int nbytes);
        int w;
        w = $clog2(nbytes);
        return (w < 3) ? 3 : w;
    endfunction

endpackage

// File: rtl/latch_readout.sv
// Two-channel latch readout: snapshots a latched counter and streams it as a byte frame.
// Build option LATCH_READOUT_CHKSUM_EN appends an XOR checksum byte to each frame.
//
// state | meaning
// IDLE  | waiting for an armed channel with a (registered) ready request
// HDR   | presenting the granted channel's header byte
// DATA  | presenting snapshot bytes, most-significant first
// CHK   | presenting XOR of header and data bytes (checksum build only)
// ACK   | one-cycle release pulse to the granted latch, disarm that channel
module latch_readout
    import latch_readout_pkg::*;
#(
    parameter int         pWIDTH = DEF_WIDTH,
    parameter logic [7:0] pHDR1  = DEF_HDR1,
    parameter logic [7:0] pHDR2  = DEF_HDR2
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iRdy1,
    input  logic [31:0]       i1Lo,
    input  logic [pWIDTH-33:0] i1Hi,
    input  logic              iRdy2,
    input  logic [31:0]       i2Lo,
    input  logic [pWIDTH-33:0] i2Hi,
    output logic              oRst1,
    output logic              oRst2,
    output logic [7:0]        oDATA,
    output logic              oVALID,
    input  logic              iREADY,
    output logic              oBUSY
);

    localparam int            NB   = pWIDTH / 8;
    localparam int            CW   = cnt_width(NB);
    localparam logic [CW-1:0] LAST = CW'(NB - 1);

    state_t              r_state;
    state_t              w_next;
    logic                r_rdy1, r_rdy2;
    logic                r_arm1, r_arm2;
    logic                r_pri;
    logic                r_ch;
    logic [pWIDTH-1:0]   r_snap;
    logic [CW-1:0]       r_cnt;
`ifdef LATCH_READOUT_CHKSUM_EN
    logic [7:0]          r_xor;
`endif

    logic       w_req1, w_req2, w_gnt2, w_accept;
    logic [7:0] w_hdr;

    assign w_req1   = r_rdy1 & r_arm1;
    assign w_req2   = r_rdy2 & r_arm2;
    assign w_gnt2   = w_req2 & (~w_req1 | r_pri);
    assign w_accept = oVALID & iREADY;
    assign w_hdr    = r_ch ? pHDR2 : pHDR1;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (w_req1 | w_req2) w_next = ST_HDR;
            ST_HDR:  if (w_accept) w_next = ST_DATA;
`ifdef LATCH_READOUT_CHKSUM_EN
            ST_DATA: if (w_accept && r_cnt == LAST) w_next = ST_CHK;
            ST_CHK:  if (w_accept) w_next = ST_ACK;
`else
            ST_DATA: if (w_accept && r_cnt == LAST) w_next = ST_ACK;
`endif
            ST_ACK:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        oVALID = 1'b0;
        oDATA  = 8'h00;
        oBUSY  = 1'b1;
        oRst1  = 1'b0;
        oRst2  = 1'b0;
        unique case (r_state)
            ST_IDLE: oBUSY = 1'b0;
            ST_HDR: begin
                oVALID = 1'b1;
                oDATA  = w_hdr;
            end
            ST_DATA: begin
                oVALID = 1'b1;
                oDATA  = r_snap[pWIDTH-1 -: 8];
            end
`ifdef LATCH_READOUT_CHKSUM_EN
            ST_CHK: begin
                oVALID = 1'b1;
                oDATA  = r_xor;
            end
`endif
            ST_ACK: begin
                oRst1 = ~r_ch;
                oRst2 = r_ch;
            end
            default: oBUSY = 1'b0;
        endcase
    end

    // Ready is registered first; arm only re-sets once the registered ready is seen low.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_rdy1 <= 1'b0;
            r_rdy2 <= 1'b0;
            r_arm1 <= 1'b1;
            r_arm2 <= 1'b1;
            r_pri  <= 1'b0;
            r_ch   <= 1'b0;
            r_snap <= '0;
            r_cnt  <= '0;
`ifdef LATCH_READOUT_CHKSUM_EN
            r_xor  <= 8'h00;
`endif
        end else begin
            r_rdy1 <= iRdy1;
            r_rdy2 <= iRdy2;
            if (!r_rdy1) r_arm1 <= 1'b1;
            if (!r_rdy2) r_arm2 <= 1'b1;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_req1 | w_req2) begin
                        r_ch   <= w_gnt2;
                        r_snap <= w_gnt2 ? {i2Hi, i2Lo} : {i1Hi, i1Lo};
                        r_cnt  <= '0;
                        if (w_req1 & w_req2) r_pri <= ~w_gnt2;
                    end
                end
`ifdef LATCH_READOUT_CHKSUM_EN
                ST_HDR: if (w_accept) r_xor <= w_hdr;
`endif
                ST_DATA: begin
                    if (w_accept) begin
                        r_snap <= r_snap << 8;
                        r_cnt  <= r_cnt + 1'b1;
`ifdef LATCH_READOUT_CHKSUM_EN
                        r_xor  <= r_xor ^ r_snap[pWIDTH-1 -: 8];
`endif
                    end
                end
                ST_ACK: begin
                    if (r_ch) r_arm2 <= 1'b0;
                    else      r_arm1 <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_latch_readout.sv
// Directed bench for latch_readout: framing, arbitration, stalls, re-arm and mid-frame reset.
module tb_latch_readout;

    logic        iCLK = 1'b0;
    logic        iRST_N = 1'b0;
    logic        iRdy1 = 1'b0, iRdy2 = 1'b0, iREADY = 1'b1;
    logic [31:0] i1Lo = '0, i1Hi = '0, i2Lo = '0, i2Hi = '0;
    logic        oRst1, oRst2, oVALID, oBUSY;
    logic [7:0]  oDATA;

    int n_run = 0;
    int n_fail = 0;

    latch_readout dut (
        .iCLK(iCLK), .iRST_N(iRST_N),
        .iRdy1(iRdy1), .i1Lo(i1Lo), .i1Hi(i1Hi),
        .iRdy2(iRdy2), .i2Lo(i2Lo), .i2Hi(i2Hi),
        .oRst1(oRst1), .oRst2(oRst2),
        .oDATA(oDATA), .oVALID(oVALID), .iREADY(iREADY), .oBUSY(oBUSY)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; receives one whole frame, then checks the ACK pulse and return to idle.
    task automatic recv(input logic [7:0] hdr, input logic [63:0] val, input bit ch2, input bit stall);
        logic [7:0] eb [10];
        logic [3:0] pat;
        int n, idx, k, g;
        logic rd;
        pat = 4'b1001;
        eb[0] = hdr;
        for (int i = 0; i < 8; i++) eb[i+1] = val[63-8*i -: 8];
        n = 9;
`ifdef LATCH_READOUT_CHKSUM_EN
        eb[9] = 8'h00;
        for (int i = 0; i < 9; i++) eb[9] = eb[9] ^ eb[i];
        n = 10;
`endif
        g = 0;
        while (oVALID !== 1'b1 && g < 40) begin
            @(negedge iCLK);
            g++;
        end
        chk("frame_start", oVALID, 1'b1);
        idx = 0;
        k = 0;
        while (idx < n && k < 200) begin
            chk("valid", oVALID, 1'b1);
            chk("byte", oDATA, eb[idx]);
            chk("no_rst_midframe", {oRst1, oRst2}, 2'b00);
            rd = stall ? pat[3 - (k % 4)] : 1'b1;
            iREADY = rd;
            if (rd) idx++;
            @(negedge iCLK);
            k++;
        end
        chk("frame_bytes", idx, n);
        iREADY = 1'b1;
        chk("ack_rst", {oRst1, oRst2}, ch2 ? 2'b01 : 2'b10);
        chk("ack_valid", oVALID, 1'b0);
        chk("ack_busy", oBUSY, 1'b1);
        @(negedge iCLK);
        chk("idle_rst", {oRst1, oRst2}, 2'b00);
        chk("idle_busy", oBUSY, 1'b0);
        chk("idle_valid", oVALID, 1'b0);
    endtask

    initial begin
        int g;
        // Reset state
        @(negedge iCLK);
        chk("rst_valid", oVALID, 1'b0);
        chk("rst_data", oDATA, 8'h00);
        chk("rst_rst", {oRst1, oRst2}, 2'b00);
        chk("rst_busy", oBUSY, 1'b0);
        iRST_N = 1'b1;
        @(negedge iCLK);

        // Basic channel-1 frame with two-cycle latency
        i1Hi = 32'h01234567;
        i1Lo = 32'h89ABCDEF;
        iRdy1 = 1'b1;
        @(negedge iCLK);
        chk("latency_1cyc", oVALID, 1'b0);
        @(negedge iCLK);
        chk("latency_2cyc", oVALID, 1'b1);
        recv(8'hA1, 64'h0123456789ABCDEF, 1'b0, 1'b0);

        // Still-high ready must not retrigger
        for (int i = 0; i < 20; i++) begin
            chk("no_dup_valid", oVALID, 1'b0);
            @(negedge iCLK);
        end

        // Snapshot isolation and ready dropping mid-frame
        iRdy1 = 1'b0;
        i1Hi = 32'h11223344;
        i1Lo = 32'h55667788;
        repeat (2) @(negedge iCLK);
        iRdy1 = 1'b1;
        repeat (2) @(negedge iCLK);
        chk("snap_hdr", oDATA, 8'hA1);
        iRdy1 = 1'b0;
        i1Hi = 32'hDEADBEEF;
        i1Lo = 32'hCAFEF00D;
        recv(8'hA1, 64'h1122334455667788, 1'b0, 1'b0);
        repeat (2) @(negedge iCLK);

        // Round-robin: simultaneous requests
        i1Hi = 32'h01234567;
        i1Lo = 32'h89ABCDEF;
        i2Hi = 32'hFEDCBA98;
        i2Lo = 32'h76543210;
        iRdy1 = 1'b1;
        iRdy2 = 1'b1;
        recv(8'hA1, 64'h0123456789ABCDEF, 1'b0, 1'b0);
        recv(8'hA2, 64'hFEDCBA9876543210, 1'b1, 1'b0);
        iRdy1 = 1'b0;
        iRdy2 = 1'b0;
        repeat (3) @(negedge iCLK);
        iRdy1 = 1'b1;
        iRdy2 = 1'b1;
        recv(8'hA2, 64'hFEDCBA9876543210, 1'b1, 1'b0);
        recv(8'hA1, 64'h0123456789ABCDEF, 1'b0, 1'b0);
        iRdy1 = 1'b0;
        iRdy2 = 1'b0;
        repeat (3) @(negedge iCLK);

        // Sink stalls with a 1,0,0,1 ready pattern
        i1Hi = 32'hA5C3E1F0;
        i1Lo = 32'h0F1E2D3C;
        iRdy1 = 1'b1;
        recv(8'hA1, 64'hA5C3E1F00F1E2D3C, 1'b0, 1'b1);
        iRdy1 = 1'b0;
        repeat (3) @(negedge iCLK);

        // Reset mid-frame after the third data byte
        i1Hi = 32'h01234567;
        i1Lo = 32'h89ABCDEF;
        iRdy1 = 1'b1;
        g = 0;
        while (oVALID !== 1'b1 && g < 40) begin
            @(negedge iCLK);
            g++;
        end
        chk("rstmid_start", oVALID, 1'b1);
        repeat (4) begin
            iREADY = 1'b1;
            @(negedge iCLK);
        end
        chk("rstmid_next_byte", oDATA, 8'h67);
        iREADY = 1'b0;
        iRST_N = 1'b0;
        #1;
        chk("rstmid_valid", oVALID, 1'b0);
        chk("rstmid_busy", oBUSY, 1'b0);
        chk("rstmid_data", oDATA, 8'h00);
        for (int i = 0; i < 2; i++) begin
            @(negedge iCLK);
            chk("rstmid_no_pulse", oRst1, 1'b0);
        end
        iRST_N = 1'b1;
        iREADY = 1'b1;
        recv(8'hA1, 64'h0123456789ABCDEF, 1'b0, 1'b0);
        iRdy1 = 1'b0;
        repeat (2) @(negedge iCLK);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
